// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the mdu_seq multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DONE   = 3'd2,
    ABS_A  = 3'd3,
    ABS_B  = 3'd4,
    FIX_LO = 3'd5,
    FIX_HI = 3'd6
  } state_t;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam int   OP_SIGNED = 1;

  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the EX stage and the mdu_seq HI/LO unit.
interface mdu_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq_addsub32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_gc;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = ci;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign w_c[B]   = w_gc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
    if (k < 7) begin : g_next
      assign w_gc[k+1] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
    end
  end

  assign s = w_p ^ w_c;
endmodule

// File: rtl/mdu_seq.sv
// Iterative HI/LO multiply/divide sequencer (shift-add / restoring divide) over one shared adder.
// Define MDU_SIGNED_EN to add signed MULT/DIV via ABS_A/ABS_B/FIX_LO/FIX_HI.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic   clk,
  input  logic   reset,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(ITER);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_mcand;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_mcand_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_div, w_div_nxt;

  logic [31:0] w_add_a, w_add_b, w_sum;
  logic        w_ci, w_co, w_q;
  logic [31:0] w_r33_lo;

`ifdef MDU_SIGNED_EN
  logic r_sgn, r_sa, r_sb, r_c;
  logic w_sgn_nxt, w_sa_nxt, w_sb_nxt, w_c_nxt;
`endif

  addsub32 u_addsub (.a(w_add_a), .b(w_add_b), .ci(w_ci), .s(w_sum));

  assign w_co     = (w_add_a[31] & w_add_b[31]) | ((w_add_a[31] | w_add_b[31]) & ~w_sum[31]);
  assign w_r33_lo = {r_hi[30:0], r_lo[31]};
  assign w_q      = r_hi[31] | w_co;

  // Adder operand / carry-in selection, kept apart from next-state logic to avoid a comb loop.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    w_ci    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (r_div) begin
          w_add_a = w_r33_lo;
          w_add_b = ~r_mcand;
          w_ci    = 1'b1;
        end else begin
          w_add_a = r_hi;
          w_add_b = r_mcand;
        end
      end
`ifdef MDU_SIGNED_EN
      ABS_A: begin
        w_add_a = r_div ? ~r_lo : ~r_mcand;
        w_ci    = 1'b1;
      end
      ABS_B: begin
        w_add_a = r_div ? ~r_mcand : ~r_lo;
        w_ci    = 1'b1;
      end
      FIX_LO: begin
        w_add_a = ~r_lo;
        w_ci    = 1'b1;
      end
      FIX_HI: begin
        w_add_a = ~r_hi;
        w_ci    = r_div ? 1'b1 : r_c;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_mcand_nxt = r_mcand;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
`ifdef MDU_SIGNED_EN
    w_sgn_nxt   = r_sgn;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_c_nxt     = r_c;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_div_nxt = bus.op[0];
          w_hi_nxt  = '0;
          w_cnt_nxt = '0;
          if (bus.op[0] == OP_DIV) begin
            w_lo_nxt    = bus.a;
            w_mcand_nxt = bus.b;
          end else begin
            w_lo_nxt    = bus.b;
            w_mcand_nxt = bus.a;
          end
`ifdef MDU_SIGNED_EN
          w_sgn_nxt   = bus.op[OP_SIGNED];
          w_sa_nxt    = bus.op[OP_SIGNED] & bus.a[31];
          w_sb_nxt    = bus.op[OP_SIGNED] & bus.b[31];
          w_state_nxt = bus.op[OP_SIGNED] ? ABS_A : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (r_div) begin
          w_lo_nxt = {r_lo[30:0], w_q};
          w_hi_nxt = w_q ? w_sum : w_r33_lo;
        end else if (r_lo[0]) begin
          {w_hi_nxt, w_lo_nxt} = {w_co, w_sum, r_lo[31:1]};
        end else begin
          {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[31:1]};
        end
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == ITER_LAST) begin
`ifdef MDU_SIGNED_EN
          w_state_nxt = r_sgn ? FIX_LO : DONE;
`else
          w_state_nxt = DONE;
`endif
        end
      end
      DONE: w_state_nxt = IDLE;
`ifdef MDU_SIGNED_EN
      // Operand a lives in lo for divide and in mcand for multiply; b is the other one.
      ABS_A: begin
        if (r_sa) begin
          if (r_div) w_lo_nxt = w_sum;
          else       w_mcand_nxt = w_sum;
        end
        w_state_nxt = ABS_B;
      end
      ABS_B: begin
        if (r_sb) begin
          if (r_div) w_mcand_nxt = w_sum;
          else       w_lo_nxt = w_sum;
        end
        w_state_nxt = RUN;
      end
      FIX_LO: begin
        if (r_sa ^ r_sb) begin
          w_lo_nxt = w_sum;
          w_c_nxt  = w_co;
        end
        w_state_nxt = FIX_HI;
      end
      FIX_HI: begin
        if (r_div ? r_sa : (r_sa ^ r_sb)) w_hi_nxt = w_sum;
        w_state_nxt = DONE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
`ifdef MDU_SIGNED_EN
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_c     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_mcand <= w_mcand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
`ifdef MDU_SIGNED_EN
      r_sgn   <= w_sgn_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_c     <= w_c_nxt;
`endif
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus hand-written start-ignore and reset sequences.
module tb_mdu_seq;
  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mdu_seq_if bus ();

  mdu_seq dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drives start in cycle 0; returns at the negedge of cycle 1 with operands scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int   cyc;
    logic busy_ok;
    logic [31:0] hi_s, lo_s;
    issue(v.op, v.a, v.b);
    cyc     = 1;
    busy_ok = 1'b1;
    while (cyc < 200 && bus.done !== 1'b1) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    chk({nm, " latency"}, cyc, v.exp_lat);
    chk({nm, " hi"}, bus.hi, v.exp_hi);
    chk({nm, " lo"}, bus.lo, v.exp_lo);
    chk({nm, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    hi_s = bus.hi;
    lo_s = bus.lo;
    @(negedge clk);
    @(negedge clk);
    chk({nm, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    chk({nm, " hold_lo"}, bus.lo, lo_s);
    chk({nm, " hold_hi"}, bus.hi, hi_s);
  endtask

  initial begin
    int cyc;
    n_total   = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;

    vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
    vecs.push_back('{2'd1, 32'd100,      32'd7,        32'd2,        32'd14,       33});
    vecs.push_back('{2'd1, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 33});
    vecs.push_back('{2'd0, 32'd6,        32'd7,        32'd0,        32'd42,       33});
    vecs.push_back('{2'd0, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        33});
    vecs.push_back('{2'd0, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 33});
    vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33});
    vecs.push_back('{2'd1, 32'd5,        32'd9,        32'd5,        32'd0,        33});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'd0,        32'd1,        33});
    vecs.push_back('{2'd0, 32'd0,        32'hDEADBEEF, 32'd0,        32'd0,        33});
`ifdef MDU_SIGNED_EN
    vecs.push_back('{2'd2, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 37});
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 37});
    vecs.push_back('{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 37});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        37});
    vecs.push_back('{2'd2, 32'd6,        32'd7,        32'd0,        32'd42,       37});
`else
    vecs.push_back('{2'd2, 32'hFFFFFFFD, 32'd5,        32'd4,        32'hFFFFFFF1, 33});
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 33});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33});
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start pulses in cycle 5 (RUN) and 33 (DONE) must both be ignored.
    issue(2'd0, 32'd3, 32'd5);
    cyc = 1;
    while (cyc < 200 && bus.done !== 1'b1) begin
      bus.start = (cyc == 5);
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(negedge clk);
      cyc++;
    end
    chk("ignore latency", cyc, 33);
    chk("ignore hi", bus.hi, 32'd0);
    chk("ignore lo", bus.lo, 32'd15);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignore idle34", {30'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    chk("ignore idle35", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("ignore hold lo", bus.lo, 32'd15);

    // Reset in cycle 10 of a divide wipes everything.
    issue(2'd1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset done", {31'd0, bus.done}, 32'd0);
    chk("midreset hi", bus.hi, 32'd0);
    chk("midreset lo", bus.lo, 32'd0);
    run_vec("post_reset_mul", '{2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 33});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS HI/LO unit.
- Runs MULTU/DIVU (and MULT/DIV when the optional feature is enabled) as a 32-step shift-add or restoring-divide loop.
- All arithmetic goes through one internal 32-bit carry-lookahead add/sub instance.
- Sits beside the ALU in EX and stalls the pipeline via busy.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  op[0]: 0 = multiply, 1 = divide; op[1]: 1 = signed (honoured only with the optional feature)
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse; hi/lo valid this cycle
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset forces state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. This holds even mid-operation; no partial result survives.
- The adder has ports s, a, b and carry-in only. Subtraction x−y is performed as x + ~y with carry-in 1.
- Carry-out is derived locally as co = a31&b31 | (a31|b31)&~s31.
- States: IDLE, RUN, DONE. With the feature enabled, ABS_A, ABS_B, FIX_LO and FIX_HI are added.
- IDLE:
  - start=1 latches a, b and op.
  - Multiply: hi=0, lo=b, mcand=a.
  - Divide: hi=0 (remainder), lo=a, divisor=b.
  - Transition to RUN, counter=0.
- RUN, multiply step:
  - If lo[0]=1: {co,sum} = hi + mcand. Otherwise {co,sum} = {0,hi}.
  - Then {hi,lo} = {co,sum,lo[31:1]}.
- RUN, divide step:
  - r33 = {hi,lo[31]}; lo shifts left by 1.
  - Trial = r33[31:0] − divisor.
  - If r33[32] | co: hi=trial, lo[0]=1. Otherwise hi=r33[31:0], lo[0]=0.
- RUN lasts exactly 32 cycles (counter 0..31), then goes to DONE.
- DONE: done=1 for one cycle, then IDLE. Unsigned latency: start sampled in cycle 0, done in cycle 33.
- After DONE, hi/lo hold their values until the next accepted start. During RUN they are intermediate and not valid.
- start while busy is ignored, with no queueing. start in the DONE cycle is also ignored.
- Divide by zero yields the natural restoring result, lo=0xFFFFFFFF and hi=dividend, with no exception. MIPS leaves this undefined; we fix it.
- Operand changes after the start cycle have no effect.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined: when op[1]=1, the sequence is IDLE → ABS_A → ABS_B → RUN → FIX_LO → FIX_HI → DONE. Latency is 37 cycles, every time.
  - ABS_A and ABS_B replace negative operands by ~x+1 using the adder.
  - Sign flags are recorded: neg_res = sa^sb for multiply and quotient; neg_rem = sa.
  - Multiply, if neg_res: FIX_LO sets lo=~lo+1 and captures its carry-out c; FIX_HI sets hi=~hi+c. That is a 64-bit negation.
  - Divide: FIX_LO negates lo if neg_res; FIX_HI negates hi if neg_rem.
  - Fix states with nothing to negate still take their cycle.
- Undefined: op[1] is ignored, all ops are unsigned, and the extra states are not synthesised.

Decomposition:
- Package mdu_pkg holds:
  - state enum: IDLE, RUN, DONE, ABS_A, ABS_B, FIX_LO, FIX_HI
  - op constants: OP_MUL=0, OP_DIV=1, OP_SIGNED bit index 1
  - ITER_LAST=31
- One sub-module: the existing addsub32 adder, instantiated once. Its operand and carry-in muxes are driven from the FSM.
- No new sub-module.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → cycle 33: done=1, hi=0xFFFFFFFE, lo=0x00000001. busy=1 in cycles 1..33.
- DIVU a=100, b=7 → lo=14, hi=2. DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678.
- start pulsed again in cycles 5 and 33 during a MULTU 3×5 → ignored. Single done at cycle 33 with hi=0, lo=15, then IDLE.
- reset asserted in cycle 10 of a DIVU → next cycle busy=0, done=0, hi=lo=0. A fresh MULTU 6×7 then gives lo=42 at cycle 33.
- With MDU_SIGNED_EN: MULT −3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at cycle 37. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Without MDU_SIGNED_EN: op=3 with a=0xFFFFFFF9, b=2 → unsigned result lo=0x7FFFFFFC, hi=1 at cycle 33.
